// File: rtl/cpu_clk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_clk_pkg : mode encodings and divider states for cpu_clk_ctrl     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package cpu_clk_pkg;

  localparam logic [1:0] MODE_RUN   = 2'd0;
  localparam logic [1:0] MODE_STEP  = 2'd1;
  localparam logic [1:0] MODE_HALT  = 2'd2;
  localparam logic [1:0] MODE_UNTIL = 2'd3;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_HIGH = 2'd1,
    S_PARK = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_debounce : 2-FF synchroniser plus stable-level debounce counter  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk50M,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_dout;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  // The new level is accepted on the cycle it completes its stable run,
  // so rise fires one cycle ahead of dout changing.
  assign w_accept = (r_sync2 != r_dout) && (r_cnt == CNT_LAST);
  assign rise     = w_accept && r_sync2;
  assign dout     = r_dout;

  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_dout) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt  <= '0;
        r_dout <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_clk_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_clk_ctrl : divided CPU clock with run/step/halt/until modes      |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module cpu_clk_ctrl #(
  parameter int CNT_WIDTH       = 24,
  parameter int CYC_WIDTH       = 32,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 clk50M,
  input  logic                 rst,
  input  logic [CNT_WIDTH-1:0] speed,
  input  logic [1:0]           mode,
  input  logic                 step_btn,
  input  logic [CYC_WIDTH-1:0] run_limit,
  input  logic                 cnt_clr,
  output logic                 clk_cpu,
  output logic                 cpu_tick,
  output logic [CYC_WIDTH-1:0] cyc_cnt,
  output logic                 halted
);

  import cpu_clk_pkg::*;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 r_clk;
  logic                 w_clk_nxt;
  logic                 r_tick;
  logic [CYC_WIDTH-1:0] r_cyc;
  logic                 r_step_pend;
  logic                 w_step_level;
  logic                 w_step_rise;
  logic                 w_terminal;
  logic                 w_may_rise;
  logic                 w_do_rise;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debounce (
    .clk50M(clk50M),
    .rst   (rst),
    .din   (step_btn),
    .dout  (w_step_level),
    .rise  (w_step_rise)
  );

  assign w_terminal = (r_cnt >= speed);

  always_comb begin
    w_may_rise = 1'b0;
    case (mode)
      MODE_RUN:   w_may_rise = 1'b1;
      MODE_STEP:  w_may_rise = r_step_pend;
      MODE_UNTIL: w_may_rise = (r_cyc < run_limit);
      default:    w_may_rise = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_WIDTH'(1);
    w_clk_nxt   = r_clk;
    w_do_rise   = 1'b0;
    case (r_state)
      S_LOW: begin
        if (w_terminal) begin
          w_cnt_nxt = '0;
          if (w_may_rise) begin
            w_state_nxt = S_HIGH;
            w_clk_nxt   = 1'b1;
            w_do_rise   = 1'b1;
          end else begin
            w_state_nxt = S_PARK;
          end
        end
      end
      // A high half always runs to completion, whatever the mode does.
      S_HIGH: begin
        if (w_terminal) begin
          w_state_nxt = S_LOW;
          w_clk_nxt   = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      S_PARK: begin
        w_cnt_nxt = '0;
        if (w_may_rise) begin
          w_state_nxt = S_HIGH;
          w_clk_nxt   = 1'b1;
          w_do_rise   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_LOW;
        w_cnt_nxt   = '0;
        w_clk_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_clk   <= w_clk_nxt;
      r_tick  <= w_do_rise;
    end
  end

  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      r_cyc <= '0;
    end else if (cnt_clr) begin
      r_cyc <= '0;
    end else if (w_do_rise && (r_cyc != {CYC_WIDTH{1'b1}})) begin
      r_cyc <= r_cyc + CYC_WIDTH'(1);
    end
  end

  // Presses arriving while a step is already pending are dropped.
  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      r_step_pend <= 1'b0;
    end else if (mode != MODE_STEP) begin
      r_step_pend <= 1'b0;
    end else if (w_do_rise) begin
      r_step_pend <= 1'b0;
    end else if (w_step_rise && !w_step_level) begin
      r_step_pend <= 1'b1;
    end
  end

  assign clk_cpu  = r_clk;
  assign cpu_tick = r_tick;
  assign cyc_cnt  = r_cyc;
  assign halted   = (r_state == S_PARK);

endmodule
`default_nettype wire
